// File: rtl/dram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_cmd_responder
// Description : DDR4 device-side model for the controller command stream.
//               It tracks the bank state and open row of 16 banks, checks each
//               ACT/RD/WR/PRE command against the DDR4 timing rules and
//               returns the read bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_cmd_responder #(
  parameter int T_RCD   = 24,
  parameter int T_CAS   = 24,
  parameter int T_CWD   = 20,
  parameter int T_BURST = 4,
  parameter int T_RP    = 24,
  parameter int T_RAS   = 52,
  parameter int T_RTP   = 12,
  parameter int T_WR    = 20,
  parameter int T_CCD_L = 8,
  parameter int T_CCD_S = 4,
  parameter int T_RRD_L = 6,
  parameter int T_RRD_S = 4,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd,
  input  logic [1:0]  cmd_bg,
  input  logic [1:0]  cmd_bank,
  input  logic [14:0] cmd_row,
  input  logic [7:0]  cmd_col,
  output logic        rd_valid,
  output logic [1:0]  rd_bg,
  output logic [1:0]  rd_bank,
  output logic [7:0]  rd_col,
  output logic [1:0]  rd_beat,
  output logic        wr_accept,
  output logic        err_valid,
  output logic [3:0]  err_code,
  output logic [15:0] bank_open
);

  localparam int         c_num_banks = 16;
  localparam int         c_num_bgs   = 4;
  localparam int         c_dl_depth  = T_CAS - 1;
  localparam logic [1:0] c_cmd_act   = 2'd0;
  localparam logic [1:0] c_cmd_rd    = 2'd1;
  localparam logic [1:0] c_cmd_wr    = 2'd2;
  localparam logic [1:0] c_cmd_pre   = 2'd3;
  localparam logic [1:0] c_last_beat = 2'(T_BURST - 1);

  // A timer holds (elapsed cycles - 1): it reads 0 in the cycle after its
  // command, so a rule of "at least P cycles" is met when timer >= P-1.
  localparam logic [CW-1:0] c_rcd    = CW'(T_RCD - 1);
  localparam logic [CW-1:0] c_rp     = CW'(T_RP - 1);
  localparam logic [CW-1:0] c_ras    = CW'(T_RAS - 1);
  localparam logic [CW-1:0] c_rtp    = CW'(T_RTP - 1);
  localparam logic [CW-1:0] c_ccd_l  = CW'(T_CCD_L - 1);
  localparam logic [CW-1:0] c_ccd_s  = CW'(T_CCD_S - 1);
  localparam logic [CW-1:0] c_rrd_l  = CW'(T_RRD_L - 1);
  localparam logic [CW-1:0] c_rrd_s  = CW'(T_RRD_S - 1);
  // Write recovery is counted from the end of the write data, which itself
  // ends T_CWD+T_BURST after the WR. Timing from the WR folds both in.
  localparam logic [CW-1:0] c_wr_pre = CW'(T_CWD + T_BURST + T_WR - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } bank_state_t;

  bank_state_t   state_q [c_num_banks];
  bank_state_t   state_d [c_num_banks];
  logic [14:0]   row_q   [c_num_banks];
  logic [14:0]   row_d   [c_num_banks];
  logic [CW-1:0] act_t_q [c_num_banks];
  logic [CW-1:0] act_t_d [c_num_banks];
  logic [CW-1:0] pre_t_q [c_num_banks];
  logic [CW-1:0] pre_t_d [c_num_banks];
  logic [CW-1:0] rd_t_q  [c_num_banks];
  logic [CW-1:0] rd_t_d  [c_num_banks];
  logic [CW-1:0] wr_t_q  [c_num_banks];
  logic [CW-1:0] wr_t_d  [c_num_banks];
  logic [CW-1:0] bg_act_t_q [c_num_bgs];
  logic [CW-1:0] bg_act_t_d [c_num_bgs];
  logic [CW-1:0] bg_col_t_q [c_num_bgs];
  logic [CW-1:0] bg_col_t_d [c_num_bgs];
  logic [CW-1:0] glob_act_t_q, glob_act_t_d;
  logic [CW-1:0] glob_col_t_q, glob_col_t_d;

  logic          dl_vld_q [c_dl_depth];
  logic          dl_vld_d [c_dl_depth];
  logic [11:0]   dl_tag_q [c_dl_depth];
  logic [11:0]   dl_tag_d [c_dl_depth];

  logic          rd_valid_q, rd_valid_d;
  logic [1:0]    rd_beat_q,  rd_beat_d;
  logic [11:0]   rd_tag_q,   rd_tag_d;
  logic          wr_accept_q, wr_accept_d;
  logic          err_valid_q, err_valid_d;
  logic [3:0]    err_code_q,  err_code_d;

  logic [3:0]    idx;
  logic [3:0]    chk_code;
  logic          accept;

  assign idx    = {cmd_bg, cmd_bank};
  assign accept = cmd_valid && (chk_code == 4'd0);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] t);
    return (t == {CW{1'b1}}) ? t : t + CW'(1);
  endfunction

  // Legality and timing check; the lowest failing code is reported.
  always_comb begin
    chk_code = 4'd0;
    if (cmd_valid) begin
      case (cmd)
        c_cmd_act: begin
          if (state_q[idx] == S_ACTIVE)                                     chk_code = 4'd1;
          else if (bg_act_t_q[cmd_bg] < c_rrd_l || glob_act_t_q < c_rrd_s) chk_code = 4'd5;
          else if (pre_t_q[idx] < c_rp)                                     chk_code = 4'd6;
        end
        c_cmd_rd, c_cmd_wr: begin
          if (state_q[idx] != S_ACTIVE)                                     chk_code = 4'd2;
          else if (act_t_q[idx] < c_rcd)                                    chk_code = 4'd3;
          else if (bg_col_t_q[cmd_bg] < c_ccd_l || glob_col_t_q < c_ccd_s) chk_code = 4'd4;
        end
        default: begin
          // PRE to an idle bank is a harmless no-op and is never timed.
          if (state_q[idx] == S_ACTIVE) begin
            if (act_t_q[idx] < c_ras)        chk_code = 4'd7;
            else if (rd_t_q[idx] < c_rtp)    chk_code = 4'd8;
            else if (wr_t_q[idx] < c_wr_pre) chk_code = 4'd9;
          end
        end
      endcase
    end
  end

  // Bank state and timer updates: timers free-run, an accepted command restarts its own.
  always_comb begin
    for (int i = 0; i < c_num_banks; i++) begin
      state_d[i] = state_q[i];
      row_d[i]   = row_q[i];
      act_t_d[i] = sat_inc(act_t_q[i]);
      pre_t_d[i] = sat_inc(pre_t_q[i]);
      rd_t_d[i]  = sat_inc(rd_t_q[i]);
      wr_t_d[i]  = sat_inc(wr_t_q[i]);
    end
    for (int g = 0; g < c_num_bgs; g++) begin
      bg_act_t_d[g] = sat_inc(bg_act_t_q[g]);
      bg_col_t_d[g] = sat_inc(bg_col_t_q[g]);
    end
    glob_act_t_d = sat_inc(glob_act_t_q);
    glob_col_t_d = sat_inc(glob_col_t_q);
    if (accept) begin
      case (cmd)
        c_cmd_act: begin
          state_d[idx]       = S_ACTIVE;
          row_d[idx]         = cmd_row;
          act_t_d[idx]       = '0;
          bg_act_t_d[cmd_bg] = '0;
          glob_act_t_d       = '0;
        end
        c_cmd_rd: begin
          rd_t_d[idx]        = '0;
          bg_col_t_d[cmd_bg] = '0;
          glob_col_t_d       = '0;
        end
        c_cmd_wr: begin
          wr_t_d[idx]        = '0;
          bg_col_t_d[cmd_bg] = '0;
          glob_col_t_d       = '0;
        end
        default: begin
          if (state_q[idx] == S_ACTIVE) begin
            state_d[idx] = S_IDLE;
            pre_t_d[idx] = '0;
          end
        end
      endcase
    end
  end

  // Registered command responses: error pulse/code and write acknowledge.
  always_comb begin
    err_valid_d = cmd_valid && (chk_code != 4'd0);
    err_code_d  = chk_code;
    wr_accept_d = accept && (cmd == c_cmd_wr);
  end

  // Read latency delay line; its last stage launches the burst at N+T_CAS.
  always_comb begin
    dl_vld_d[0] = accept && (cmd == c_cmd_rd);
    dl_tag_d[0] = {cmd_bg, cmd_bank, cmd_col};
    for (int i = 1; i < c_dl_depth; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
  end

  // Burst sequencer: a new burst starts at beat 0, otherwise step to the last beat.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_beat_d  = 2'd0;
    rd_tag_d   = 12'd0;
    if (dl_vld_q[c_dl_depth-1]) begin
      rd_valid_d = 1'b1;
      rd_tag_d   = dl_tag_q[c_dl_depth-1];
    end else if (rd_valid_q && rd_beat_q != c_last_beat) begin
      rd_valid_d = 1'b1;
      rd_beat_d  = rd_beat_q + 2'd1;
      rd_tag_d   = rd_tag_q;
    end
  end

  // State registers; reset drops any read in flight and saturates all timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_num_banks; i++) begin
        state_q[i] <= S_IDLE;
        row_q[i]   <= '0;
        act_t_q[i] <= '1;
        pre_t_q[i] <= '1;
        rd_t_q[i]  <= '1;
        wr_t_q[i]  <= '1;
      end
      for (int g = 0; g < c_num_bgs; g++) begin
        bg_act_t_q[g] <= '1;
        bg_col_t_q[g] <= '1;
      end
      for (int i = 0; i < c_dl_depth; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_tag_q[i] <= '0;
      end
      glob_act_t_q <= '1;
      glob_col_t_q <= '1;
      rd_valid_q   <= 1'b0;
      rd_beat_q    <= 2'd0;
      rd_tag_q     <= 12'd0;
      wr_accept_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      act_t_q      <= act_t_d;
      pre_t_q      <= pre_t_d;
      rd_t_q       <= rd_t_d;
      wr_t_q       <= wr_t_d;
      bg_act_t_q   <= bg_act_t_d;
      bg_col_t_q   <= bg_col_t_d;
      glob_act_t_q <= glob_act_t_d;
      glob_col_t_q <= glob_col_t_d;
      dl_vld_q     <= dl_vld_d;
      dl_tag_q     <= dl_tag_d;
      rd_valid_q   <= rd_valid_d;
      rd_beat_q    <= rd_beat_d;
      rd_tag_q     <= rd_tag_d;
      wr_accept_q  <= wr_accept_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  // Open-bank map mirrors the per-bank state registers.
  always_comb begin
    for (int i = 0; i < c_num_banks; i++) begin
      bank_open[i] = (state_q[i] == S_ACTIVE);
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_bg     = rd_tag_q[11:10];
  assign rd_bank   = rd_tag_q[9:8];
  assign rd_col    = rd_tag_q[7:0];
  assign rd_beat   = rd_beat_q;
  assign wr_accept = wr_accept_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_cmd_responder
// Description : Self-checking bench for dram_cmd_responder. Read beats are
//               predicted into a scoreboard queue at RD issue and checked by a
//               monitor; command responses are checked inline per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_cmd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'd0;
  logic [1:0]  cmd_bg = 2'd0;
  logic [1:0]  cmd_bank = 2'd0;
  logic [14:0] cmd_row = 15'd0;
  logic [7:0]  cmd_col = 8'd0;
  logic        rd_valid;
  logic [1:0]  rd_bg;
  logic [1:0]  rd_bank;
  logic [7:0]  rd_col;
  logic [1:0]  rd_beat;
  logic        wr_accept;
  logic        err_valid;
  logic [3:0]  err_code;
  logic [15:0] bank_open;

  typedef struct {
    int         cyc;
    logic [1:0] bg;
    logic [1:0] bank;
    logic [7:0] col;
    logic [1:0] beat;
  } beat_t;

  beat_t exp_q[$];
  int    cyc    = 0;
  int    n_cmp  = 0;
  int    n_fail = 0;

  localparam int T_CAS   = 24;
  localparam int T_BURST = 4;

  dram_cmd_responder dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .rd_valid  (rd_valid),
    .rd_bg     (rd_bg),
    .rd_bank   (rd_bank),
    .rd_col    (rd_col),
    .rd_beat   (rd_beat),
    .wr_accept (wr_accept),
    .err_valid (err_valid),
    .err_code  (err_code),
    .bank_open (bank_open)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  // Present one command for the current cycle; return in the next cycle.
  task automatic send(input logic [1:0] c, input logic [1:0] bg, input logic [1:0] bk,
                      input logic [14:0] row, input logic [7:0] col);
    cmd_valid = 1'b1;
    cmd = c; cmd_bg = bg; cmd_bank = bk; cmd_row = row; cmd_col = col;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Predict the burst of an RD issued in cycle n.
  task automatic push_read(input int n, input logic [1:0] bg, input logic [1:0] bk,
                           input logic [7:0] col);
    beat_t b;
    for (int i = 0; i < T_BURST; i++) begin
      b.cyc = n + T_CAS + i; b.bg = bg; b.bank = bk; b.col = col; b.beat = 2'(i);
      exp_q.push_back(b);
    end
  endtask

  // Read-beat monitor: every beat must match the scoreboard head at its cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: cycle %0d beat %0d col %0d, none expected", cyc, rd_beat, rd_col);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (e.cyc !== cyc || e.bg !== rd_bg || e.bank !== rd_bank || e.col !== rd_col || e.beat !== rd_beat) begin
            n_fail++;
            $display("FAIL rd_beat: got cyc %0d bg %0d bank %0d col %0d beat %0d, want cyc %0d bg %0d bank %0d col %0d beat %0d",
                     cyc, rd_bg, rd_bank, rd_col, rd_beat, e.cyc, e.bg, e.bank, e.col, e.beat);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        beat_t e;
        e = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL rd_missing: rd_valid 0 at cycle %0d, want beat %0d at cycle %0d", cyc, e.beat, e.cyc);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if ({rd_valid, wr_accept, err_valid, err_code, bank_open, rd_col, rd_beat} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdv %b wra %b errv %b code %0d open %h col %0d, want all 0",
               rd_valid, wr_accept, err_valid, err_code, bank_open, rd_col);
    end
  endtask

  task automatic test_read();
    do_reset();
    send(2'd0, 2'd0, 2'd0, 15'd5, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0001) begin
      n_fail++;
      $display("FAIL read_act: got errv %b open %h, want 0 0001", err_valid, bank_open);
    end
    wait_to(24);
    push_read(24, 2'd0, 2'd0, 8'd3);
    send(2'd1, 2'd0, 2'd0, 15'd0, 8'd3);
    n_cmp++;
    if (err_valid !== 1'b0 || err_code !== 4'd0) begin
      n_fail++;
      $display("FAIL read_rd_err: got errv %b code %0d, want 0 0", err_valid, err_code);
    end
    wait_to(56);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL read_drain: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_trcd();
    do_reset();
    send(2'd0, 2'd1, 2'd2, 15'd9, 8'd0);
    wait_to(23);
    send(2'd1, 2'd1, 2'd2, 15'd0, 8'd7);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd3) begin
      n_fail++;
      $display("FAIL trcd_err: got errv %b code %0d, want 1 3", err_valid, err_code);
    end
    n_cmp++;
    if (bank_open !== 16'h0040) begin
      n_fail++;
      $display("FAIL trcd_open: got %h, want 0040", bank_open);
    end
    tick();
    n_cmp++;
    if (err_valid !== 1'b0 || err_code !== 4'd0) begin
      n_fail++;
      $display("FAIL trcd_pulse: got errv %b code %0d, want 0 0", err_valid, err_code);
    end
    wait_to(60);
  endtask

  task automatic test_rrd();
    do_reset();
    send(2'd0, 2'd0, 2'd0, 15'd1, 8'd0);
    wait_to(5);
    send(2'd0, 2'd0, 2'd1, 15'd2, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd5) begin
      n_fail++;
      $display("FAIL rrd_l: got errv %b code %0d, want 1 5", err_valid, err_code);
    end
    do_reset();
    send(2'd0, 2'd0, 2'd0, 15'd1, 8'd0);
    wait_to(5);
    send(2'd0, 2'd1, 2'd0, 15'd2, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0011) begin
      n_fail++;
      $display("FAIL rrd_s: got errv %b open %h, want 0 0011", err_valid, bank_open);
    end
  endtask

  task automatic test_ras_rp();
    do_reset();
    send(2'd0, 2'd2, 2'd1, 15'd3, 8'd0);
    wait_to(51);
    send(2'd3, 2'd2, 2'd1, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd7) begin
      n_fail++;
      $display("FAIL ras_early: got errv %b code %0d, want 1 7", err_valid, err_code);
    end
    send(2'd3, 2'd2, 2'd1, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0000) begin
      n_fail++;
      $display("FAIL ras_ok: got errv %b open %h, want 0 0000", err_valid, bank_open);
    end
    wait_to(75);
    send(2'd0, 2'd2, 2'd1, 15'd4, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd6) begin
      n_fail++;
      $display("FAIL rp_early: got errv %b code %0d, want 1 6", err_valid, err_code);
    end
    send(2'd0, 2'd2, 2'd1, 15'd4, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0200) begin
      n_fail++;
      $display("FAIL rp_ok: got errv %b open %h, want 0 0200", err_valid, bank_open);
    end
  endtask

  task automatic test_write();
    do_reset();
    send(2'd0, 2'd0, 2'd0, 15'd8, 8'd0);
    wait_to(24);
    send(2'd2, 2'd0, 2'd0, 15'd0, 8'd4);
    n_cmp++;
    if (wr_accept !== 1'b1 || err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_accept: got wra %b errv %b, want 1 0", wr_accept, err_valid);
    end
    tick();
    n_cmp++;
    if (wr_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pulse: got wra %b, want 0", wr_accept);
    end
    wait_to(67);
    send(2'd3, 2'd0, 2'd0, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd9) begin
      n_fail++;
      $display("FAIL twr_early: got errv %b code %0d, want 1 9", err_valid, err_code);
    end
    send(2'd3, 2'd0, 2'd0, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0000) begin
      n_fail++;
      $display("FAIL twr_ok: got errv %b open %h, want 0 0000", err_valid, bank_open);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(2'd0, 2'd0, 2'd0, 15'd1, 8'd0);
    wait_to(4);
    send(2'd0, 2'd1, 2'd0, 15'd2, 8'd0);
    wait_to(28);
    push_read(28, 2'd0, 2'd0, 8'd10);
    send(2'd1, 2'd0, 2'd0, 15'd0, 8'd10);
    wait_to(30);
    send(2'd1, 2'd1, 2'd0, 15'd0, 8'd20);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd4) begin
      n_fail++;
      $display("FAIL ccd_s: got errv %b code %0d, want 1 4", err_valid, err_code);
    end
    wait_to(32);
    push_read(32, 2'd1, 2'd0, 8'd21);
    send(2'd1, 2'd1, 2'd0, 15'd0, 8'd21);
    wait_to(35);
    send(2'd1, 2'd0, 2'd0, 15'd0, 8'd30);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd4) begin
      n_fail++;
      $display("FAIL ccd_l: got errv %b code %0d, want 1 4", err_valid, err_code);
    end
    push_read(36, 2'd0, 2'd0, 8'd31);
    send(2'd1, 2'd0, 2'd0, 15'd0, 8'd31);
    n_cmp++;
    if (err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ccd_ok: got errv %b code %0d, want 0 0", err_valid, err_code);
    end
    wait_to(68);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rtp();
    do_reset();
    send(2'd0, 2'd3, 2'd3, 15'd7, 8'd0);
    wait_to(60);
    push_read(60, 2'd3, 2'd3, 8'hA5);
    send(2'd1, 2'd3, 2'd3, 15'd0, 8'hA5);
    wait_to(71);
    send(2'd3, 2'd3, 2'd3, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd8) begin
      n_fail++;
      $display("FAIL rtp_early: got errv %b code %0d, want 1 8", err_valid, err_code);
    end
    send(2'd3, 2'd3, 2'd3, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0000) begin
      n_fail++;
      $display("FAIL rtp_ok: got errv %b open %h, want 0 0000", err_valid, bank_open);
    end
    wait_to(92);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rtp_drain: got %0d beats outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_legality();
    do_reset();
    send(2'd1, 2'd2, 2'd2, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd2) begin
      n_fail++;
      $display("FAIL rd_idle: got errv %b code %0d, want 1 2", err_valid, err_code);
    end
    send(2'd3, 2'd2, 2'd2, 15'd0, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || err_code !== 4'd0) begin
      n_fail++;
      $display("FAIL pre_idle: got errv %b code %0d, want 0 0", err_valid, err_code);
    end
    send(2'd0, 2'd2, 2'd2, 15'd1, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b0 || bank_open !== 16'h0400) begin
      n_fail++;
      $display("FAIL act_after_pre_idle: got errv %b code %0d open %h, want 0 0 0400", err_valid, err_code, bank_open);
    end
    send(2'd0, 2'd2, 2'd2, 15'd1, 8'd0);
    n_cmp++;
    if (err_valid !== 1'b1 || err_code !== 4'd1) begin
      n_fail++;
      $display("FAIL act_active: got errv %b code %0d, want 1 1", err_valid, err_code);
    end
    send(2'd2, 2'd2, 2'd2, 15'd0, 8'd0);
    n_cmp++;
    if (err_code !== 4'd3 || wr_accept !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_trcd: got code %0d wra %b, want 3 0", err_code, wr_accept);
    end
  endtask

  task automatic test_rst_midburst();
    do_reset();
    send(2'd0, 2'd0, 2'd0, 15'd2, 8'd0);
    wait_to(30);
    send(2'd1, 2'd0, 2'd0, 15'd0, 8'd9);
    wait_to(40);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bank_open !== 16'h0000 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got open %h rdv %b, want 0000 0", bank_open, rd_valid);
    end
    rst = 1'b0;
    wait_to(80);
  endtask

  initial begin
    test_reset();
    test_read();
    test_trcd();
    test_rrd();
    test_ras_rp();
    test_write();
    test_back_to_back();
    test_rtp();
    test_legality();
    test_rst_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
